// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the EC413 multicycle control unit: opcodes, state
// encoding, datapath select codes and the branch-condition helper.
package mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000001;
    localparam logic [5:0] OP_MOV  = 6'b010000;
    localparam logic [5:0] OP_ADD  = 6'b010010;
    localparam logic [5:0] OP_SUB  = 6'b010011;
    localparam logic [5:0] OP_OR   = 6'b010100;
    localparam logic [5:0] OP_AND  = 6'b010101;
    localparam logic [5:0] OP_SLT  = 6'b010111;
    localparam logic [5:0] OP_ADDI = 6'b110010;
    localparam logic [5:0] OP_SUBI = 6'b110011;
    localparam logic [5:0] OP_ORI  = 6'b110100;
    localparam logic [5:0] OP_ANDI = 6'b110101;
    localparam logic [5:0] OP_SLTI = 6'b110111;
    localparam logic [5:0] OP_LI   = 6'b111001;
    localparam logic [5:0] OP_LUI  = 6'b111010;
    localparam logic [5:0] OP_LWI  = 6'b111011;
    localparam logic [5:0] OP_SWI  = 6'b111100;
    localparam logic [5:0] OP_LW   = 6'b111101;
    localparam logic [5:0] OP_SW   = 6'b111110;
    localparam logic [5:0] OP_BEQ  = 6'b100000;
    localparam logic [5:0] OP_BNE  = 6'b100001;
    localparam logic [5:0] OP_BLT  = 6'b100010;
    localparam logic [5:0] OP_BLE  = 6'b100011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Instruction classes; R-type and I-type ALU ops share one class and
    // differ only in the ALU B select produced by the decoder.
    typedef enum logic [3:0] {
        CL_NOP     = 4'd0,
        CL_JUMP    = 4'd1,
        CL_ALU     = 4'd2,
        CL_LI      = 4'd3,
        CL_LUI     = 4'd4,
        CL_LOAD    = 4'd5,
        CL_STORE   = 4'd6,
        CL_BRANCH  = 4'd7,
        CL_ILLEGAL = 4'd8
    } op_class_t;

    // Branch condition, taken directly from opcode[1:0]
    typedef enum logic [1:0] {
        BR_EQ = 2'd0,
        BR_NE = 2'd1,
        BR_LT = 2'd2,
        BR_LE = 2'd3
    } br_cond_t;

    localparam logic [2:0] ALU_PASS_A = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_AND    = 3'd4;
    localparam logic [2:0] ALU_SLT    = 3'd5;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_SEXT = 2'd1;
    localparam logic [1:0] SRCB_ZEXT = 2'd2;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MDR   = 2'd1;
    localparam logic [1:0] WB_IMM   = 2'd2;
    localparam logic [1:0] WB_UPPER = 2'd3;

    // Branch resolution from the SUB flags computed in EXEC (rs - rt)
    function automatic logic branch_taken(input br_cond_t cond, input logic zero, input logic lt);
        logic taken;
        case (cond)
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            BR_LT:   taken = lt;
            BR_LE:   taken = lt | zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode decoder: instruction class plus the EXEC-phase ALU
// controls, the WB source and the branch condition.
module mc_opdecode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] wb_sel,
    output br_cond_t   br_cond
);

    // Opcode to class and select lookup; unknown opcodes fall to CL_ILLEGAL
    always_comb begin
        op_class  = CL_ILLEGAL;
        alu_op    = ALU_PASS_A;
        alu_src_b = SRCB_RT;
        wb_sel    = WB_ALU;
        br_cond   = br_cond_t'(opcode[1:0]);
        case (opcode)
            OP_NOP:  op_class = CL_NOP;
            OP_J:    op_class = CL_JUMP;
            OP_MOV:  begin op_class = CL_ALU; alu_op = ALU_PASS_A; end
            OP_ADD:  begin op_class = CL_ALU; alu_op = ALU_ADD; end
            OP_SUB:  begin op_class = CL_ALU; alu_op = ALU_SUB; end
            OP_OR:   begin op_class = CL_ALU; alu_op = ALU_OR;  end
            OP_AND:  begin op_class = CL_ALU; alu_op = ALU_AND; end
            OP_SLT:  begin op_class = CL_ALU; alu_op = ALU_SLT; end
            OP_ADDI: begin op_class = CL_ALU; alu_op = ALU_ADD; alu_src_b = SRCB_SEXT; end
            OP_SUBI: begin op_class = CL_ALU; alu_op = ALU_SUB; alu_src_b = SRCB_SEXT; end
            OP_ORI:  begin op_class = CL_ALU; alu_op = ALU_OR;  alu_src_b = SRCB_ZEXT; end
            OP_ANDI: begin op_class = CL_ALU; alu_op = ALU_AND; alu_src_b = SRCB_ZEXT; end
            OP_SLTI: begin op_class = CL_ALU; alu_op = ALU_SLT; alu_src_b = SRCB_SEXT; end
            OP_LI:   begin op_class = CL_LI;  wb_sel = WB_IMM;   end
            OP_LUI:  begin op_class = CL_LUI; wb_sel = WB_UPPER; end
            OP_LWI, OP_LW: begin
                op_class  = CL_LOAD;
                alu_op    = ALU_ADD;
                alu_src_b = SRCB_SEXT;
                wb_sel    = WB_MDR;
            end
            OP_SWI, OP_SW: begin
                op_class  = CL_STORE;
                alu_op    = ALU_ADD;
                alu_src_b = SRCB_SEXT;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BLE: begin
                op_class  = CL_BRANCH;
                alu_op    = ALU_SUB;
                alu_src_b = SRCB_RT;
            end
            default: op_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// EC413 multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// the datapath strobes and selects, and counts retired instructions.
// Strobes are decoded from the state register and the IR opcode so that the
// IR contents latched at the end of FETCH act in DECODE; while rst is high
// every strobe is held low.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             lt,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             mem_read,
    output logic             mem_write,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t     state_r;
    op_class_t  dec_class_s;
    logic [2:0] dec_alu_op_s;
    logic [1:0] dec_src_b_s;
    logic [1:0] dec_wb_sel_s;
    br_cond_t   dec_br_cond_s;
    logic       retire_s;

    mc_opdecode u_opdecode (
        .opcode    (opcode),
        .op_class  (dec_class_s),
        .alu_op    (dec_alu_op_s),
        .alu_src_b (dec_src_b_s),
        .wb_sel    (dec_wb_sel_s),
        .br_cond   (dec_br_cond_s)
    );

    assign state = state_r;

    // Strobe/select decode per state plus the retire flag for the counter
    always_comb begin
        pc_write  = 1'b0;
        pc_src    = PC_SRC_INC;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_PASS_A;
        wb_sel    = WB_ALU;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        retire_s  = 1'b0;
        if (rst) begin
            retire_s = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_INC;
                end
                ST_DECODE: begin
                    case (dec_class_s)
                        CL_NOP:     retire_s = 1'b1;
                        CL_JUMP: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_JUMP;
                            retire_s = 1'b1;
                        end
                        CL_ILLEGAL: begin
                            illegal  = 1'b1;
                            retire_s = 1'b1;
                        end
                        default:    retire_s = 1'b0;
                    endcase
                end
                ST_EXEC: begin
                    alu_op    = dec_alu_op_s;
                    alu_src_b = dec_src_b_s;
                    if (dec_class_s == CL_BRANCH) begin
                        retire_s = 1'b1;
                        if (branch_taken(dec_br_cond_s, zero, lt)) begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_BRANCH;
                        end else begin
                            pc_write = 1'b0;
                        end
                    end else begin
                        retire_s = 1'b0;
                    end
                end
                ST_MEM: begin
                    mem_read  = (dec_class_s == CL_LOAD);
                    mem_write = (dec_class_s == CL_STORE);
                    retire_s  = (dec_class_s == CL_STORE) && dmem_ready;
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = dec_wb_sel_s;
                    retire_s  = 1'b1;
                end
                default: retire_s = 1'b0;
            endcase
        end
    end

    // State sequencing and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
            retired <= {CNT_W{1'b0}};
        end else begin
            if (retire_s) begin
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired <= retired;
            end
            case (state_r)
                ST_FETCH: state_r <= ST_DECODE;
                ST_DECODE: begin
                    case (dec_class_s)
                        CL_NOP, CL_JUMP, CL_ILLEGAL: state_r <= ST_FETCH;
                        CL_LI, CL_LUI:               state_r <= ST_WB;
                        default:                     state_r <= ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    case (dec_class_s)
                        CL_LOAD, CL_STORE: state_r <= ST_MEM;
                        CL_BRANCH:         state_r <= ST_FETCH;
                        default:           state_r <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (dec_class_s == CL_LOAD) begin
                            state_r <= ST_WB;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                ST_WB:   state_r <= ST_FETCH;
                default: state_r <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the stimulus process pushes the
// hand-computed output vector for every cycle it drives, and a monitor
// pops and compares on the falling edge.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        lt = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        reg_write;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] retired;

    typedef struct packed {
        logic        pcw;
        logic [1:0]  pcs;
        logic        irw;
        logic        rw;
        logic [1:0]  asb;
        logic [2:0]  aop;
        logic [1:0]  wbs;
        logic        mr;
        logic        mw;
        logic        ill;
        logic [2:0]  st;
        logic [31:0] ret;
    } vec_t;

    typedef struct {
        string name;
        vec_t  v;
    } item_t;

    item_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_ret = 0;
    vec_t  act;

    mc_ctrl_fsm #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .lt         (lt),
        .dmem_ready (dmem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .illegal    (illegal),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    assign act = {pc_write, pc_src, ir_write, reg_write, alu_src_b, alu_op,
                  wb_sel, mem_read, mem_write, illegal, state, retired};

    function automatic vec_t mk(input logic pcw, input logic [1:0] pcs, input logic irw,
                                input logic rw, input logic [1:0] asb, input logic [2:0] aop,
                                input logic [1:0] wbs, input logic mr, input logic mw,
                                input logic ill, input logic [2:0] st);
        vec_t v;
        v = {pcw, pcs, irw, rw, asb, aop, wbs, mr, mw, ill, st, 32'd0};
        return v;
    endfunction

    // One clock of stimulus plus the output vector expected during it
    task automatic cyc(input string name, input logic r, input logic [5:0] op,
                       input logic z, input logic l, input logic rdy, input vec_t e);
        item_t it;
        @(posedge clk);
        #1;
        rst = r;
        opcode = op;
        zero = z;
        lt = l;
        dmem_ready = rdy;
        e.ret = 32'(exp_ret);
        it.name = name;
        it.v = e;
        exp_q.push_back(it);
    endtask

    task automatic fetch(input string name, input logic [5:0] op);
        cyc(name, 1'b0, op, 1'b0, 1'b0, 1'b0,
            mk(1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0));
    endtask

    task automatic decode(input string name, input logic [5:0] op);
        cyc(name, 1'b0, op, 1'b0, 1'b0, 1'b0,
            mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd1));
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            item_t it;
            it = exp_q.pop_front();
            n_vec++;
            if (act !== it.v) begin
                n_err++;
                $display("FAIL %s: actual %h (state %0d retired %0d) required %h (state %0d retired %0d)",
                         it.name, act, act.st, act.ret, it.v, it.v.st, it.v.ret);
            end
        end
    end

    initial begin
        // reset: all strobes low, FETCH, counter zero
        cyc("reset0", 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 3'd0));
        cyc("reset1", 1'b1, 6'd0, 1'b1, 1'b1, 1'b1, mk(0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 3'd0));

        // NOP then three ADDI
        fetch("nop_F", 6'b000000);
        decode("nop_D", 6'b000000);
        exp_ret++;
        for (int i = 0; i < 3; i++) begin
            fetch("addi_F", 6'b110010);
            decode("addi_D", 6'b110010);
            cyc("addi_E", 1'b0, 6'b110010, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd1, 3'd1, 2'd0, 0, 0, 0, 3'd2));
            cyc("addi_W", 1'b0, 6'b110010, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 1, 2'd0, 3'd0, 2'd0, 0, 0, 0, 3'd4));
            exp_ret++;
        end

        // BEQ taken then not taken
        fetch("beq1_F", 6'b100000);
        decode("beq1_D", 6'b100000);
        cyc("beq_taken_E", 1'b0, 6'b100000, 1'b1, 1'b0, 1'b0, mk(1, 2'd1, 0, 0, 2'd0, 3'd2, 2'd0, 0, 0, 0, 3'd2));
        exp_ret++;
        fetch("beq2_F", 6'b100000);
        decode("beq2_D", 6'b100000);
        cyc("beq_nt_E", 1'b0, 6'b100000, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd0, 3'd2, 2'd0, 0, 0, 0, 3'd2));
        exp_ret++;

        // BLE lt=0 zero=1 taken; BLT lt=0 zero=1 not taken; BNE zero=1 not taken
        fetch("ble_F", 6'b100011);
        decode("ble_D", 6'b100011);
        cyc("ble_taken_E", 1'b0, 6'b100011, 1'b1, 1'b0, 1'b0, mk(1, 2'd1, 0, 0, 2'd0, 3'd2, 2'd0, 0, 0, 0, 3'd2));
        exp_ret++;
        fetch("blt_F", 6'b100010);
        decode("blt_D", 6'b100010);
        cyc("blt_nt_E", 1'b0, 6'b100010, 1'b1, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd0, 3'd2, 2'd0, 0, 0, 0, 3'd2));
        exp_ret++;
        fetch("bne_F", 6'b100001);
        decode("bne_D", 6'b100001);
        cyc("bne_nt_E", 1'b0, 6'b100001, 1'b1, 1'b1, 1'b0, mk(0, 2'd0, 0, 0, 2'd0, 3'd2, 2'd0, 0, 0, 0, 3'd2));
        exp_ret++;

        // LWI with three wait cycles
        fetch("lwi_F", 6'b111011);
        decode("lwi_D", 6'b111011);
        cyc("lwi_E", 1'b0, 6'b111011, 1'b0, 1'b0, 1'b1, mk(0, 2'd0, 0, 0, 2'd1, 3'd1, 2'd0, 0, 0, 0, 3'd2));
        for (int i = 0; i < 3; i++) begin
            cyc("lwi_M_wait", 1'b0, 6'b111011, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0, 1, 0, 0, 3'd3));
        end
        cyc("lwi_M_rdy", 1'b0, 6'b111011, 1'b0, 1'b0, 1'b1, mk(0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0, 1, 0, 0, 3'd3));
        cyc("lwi_W", 1'b0, 6'b111011, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 1, 2'd0, 3'd0, 2'd1, 0, 0, 0, 3'd4));
        exp_ret++;

        // LI and LUI go straight to WB
        fetch("li_F", 6'b111001);
        decode("li_D", 6'b111001);
        cyc("li_W", 1'b0, 6'b111001, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 1, 2'd0, 3'd0, 2'd2, 0, 0, 0, 3'd4));
        exp_ret++;
        fetch("lui_F", 6'b111010);
        decode("lui_D", 6'b111010);
        cyc("lui_W", 1'b0, 6'b111010, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 1, 2'd0, 3'd0, 2'd3, 0, 0, 0, 3'd4));
        exp_ret++;

        // ORI (zext), MOV (pass A), SLT (rt)
        fetch("ori_F", 6'b110100);
        decode("ori_D", 6'b110100);
        cyc("ori_E", 1'b0, 6'b110100, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd2, 3'd3, 2'd0, 0, 0, 0, 3'd2));
        cyc("ori_W", 1'b0, 6'b110100, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 1, 2'd0, 3'd0, 2'd0, 0, 0, 0, 3'd4));
        exp_ret++;
        fetch("mov_F", 6'b010000);
        decode("mov_D", 6'b010000);
        cyc("mov_E", 1'b0, 6'b010000, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 3'd2));
        cyc("mov_W", 1'b0, 6'b010000, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 1, 2'd0, 3'd0, 2'd0, 0, 0, 0, 3'd4));
        exp_ret++;
        fetch("slt_F", 6'b010111);
        decode("slt_D", 6'b010111);
        cyc("slt_E", 1'b0, 6'b010111, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd0, 3'd5, 2'd0, 0, 0, 0, 3'd2));
        cyc("slt_W", 1'b0, 6'b010111, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 1, 2'd0, 3'd0, 2'd0, 0, 0, 0, 3'd4));
        exp_ret++;

        // SWI zero-wait store
        fetch("swi_F", 6'b111100);
        decode("swi_D", 6'b111100);
        cyc("swi_E", 1'b0, 6'b111100, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd1, 3'd1, 2'd0, 0, 0, 0, 3'd2));
        cyc("swi_M_rdy", 1'b0, 6'b111100, 1'b0, 1'b0, 1'b1, mk(0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 1, 0, 3'd3));
        exp_ret++;

        // J: jump in DECODE, fetch again next cycle
        fetch("j_F", 6'b000001);
        cyc("j_D", 1'b0, 6'b000001, 1'b0, 1'b0, 1'b0, mk(1, 2'd2, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 3'd1));
        exp_ret++;

        // illegal opcode 101010
        fetch("ill_F", 6'b101010);
        cyc("ill_D", 1'b0, 6'b101010, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 1, 3'd1));
        exp_ret++;

        // SW interrupted by reset while waiting in MEM
        fetch("sw_F", 6'b111110);
        decode("sw_D", 6'b111110);
        cyc("sw_E", 1'b0, 6'b111110, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd1, 3'd1, 2'd0, 0, 0, 0, 3'd2));
        cyc("sw_M_wait", 1'b0, 6'b111110, 1'b0, 1'b0, 1'b0, mk(0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 1, 0, 3'd3));
        exp_ret = 0;
        cyc("sw_rst", 1'b1, 6'b111110, 1'b0, 1'b0, 1'b1, mk(0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 3'd0));
        fetch("post_rst_F", 6'b000000);
        decode("post_rst_D", 6'b000000);
        exp_ret++;
        fetch("final_F", 6'b000000);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() > 0) begin
                @(negedge clk);
                #1;
            end
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle control unit for the EC413 CPU. Decodes the 6-bit opcode latched in the instruction register and sequences the shared datapath through FETCH, DECODE, EXEC, MEM and WB. It drives every PC, IR, register-file, ALU and data-memory strobe, and waits on a data-memory ready handshake. It sits between the IR/ALU flags and all datapath mux selects, and also keeps a retired-instruction counter for the bench.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26], the instruction register output.
- `zero` in 1: ALU result == 0.
- `lt` in 1: ALU signed less-than, i.e. rs < rt.
- `dmem_ready` in 1: data memory has completed the access.
- `pc_write` out 1: load PC.
- `pc_src` out 2: PC source. 0 = PC+1, 1 = branch target PC+sext(imm16), 2 = jump target {PC[31:26], IR[25:0]}.
- `ir_write` out 1: latch IMem instruction into IR.
- `reg_write` out 1: register-file write enable.
- `alu_src_b` out 2: ALU B input. 0 = rt, 1 = sext(imm16), 2 = zext(imm16).
- `alu_op` out 3: 0 PASS_A, 1 ADD, 2 SUB, 3 OR, 4 AND, 5 SLT.
- `wb_sel` out 2: write-back source. 0 = ALU register, 1 = MDR, 2 = zext(imm16), 3 = {imm16, 16'h0}.
- `mem_read` out 1, `mem_write` out 1: data-memory strobes.
- `illegal` out 1: one-cycle pulse in DECODE for an unknown opcode.
- `state` out 3: current state, for debug.
- `retired` out CNT_W: count of completed instructions.

## Operation
- Opcode classes:
  - NOP 000000.
  - J 000001.
  - R-type: MOV 010000, ADD 010010, SUB 010011, OR 010100, AND 010101, SLT 010111.
  - I-type ALU: ADDI 110010, SUBI 110011, ORI 110100, ANDI 110101, SLTI 110111.
  - Immediates: LI 111001, LUI 111010.
  - Loads: LWI 111011 (absolute), LW 111101 (rs-based).
  - Stores: SWI 111100 (absolute), SW 111110 (rs-based).
  - Branches: BEQ 100000, BNE 100001, BLT 100010, BLE 100011.
- FETCH:
  - Assert ir_write, pc_write and pc_src=0.
  - Next state is DECODE.
- DECODE:
  - NOP: retire, go to FETCH.
  - J: assert pc_write with pc_src=2, retire, go to FETCH.
  - LI/LUI: go to WB.
  - Illegal opcode: pulse `illegal`, retire as NOP, go to FETCH.
  - All other opcodes: go to EXEC.
- EXEC:
  - R-type: alu_src_b=0. I-type ALU: alu_src_b=1, except ORI/ANDI which use alu_src_b=2. Both go to WB.
  - MOV uses PASS_A.
  - LWI/SWI/LW/SW: alu_op ADD with alu_src_b=1, go to MEM.
  - Branches: alu_op SUB, alu_src_b=0. Taken condition:
    - BEQ: zero.
    - BNE: !zero.
    - BLT: lt.
    - BLE: lt|zero.
  - Taken branch: pc_write with pc_src=1. Branch always retires and goes to FETCH.
- MEM:
  - Hold mem_read (loads) or mem_write (stores) asserted until dmem_ready.
  - On ready, a load goes to WB; a store retires and goes to FETCH.
- WB:
  - Assert reg_write for exactly one cycle.
  - wb_sel: 0 for ALU ops, 1 for loads, 2 for LI, 3 for LUI.
  - Retire, go to FETCH.
- Unlisted outputs are 0 in every state. Outputs are Moore-decoded from state+opcode, except the branch pc_write, which also depends on zero/lt.

## Timing
- Reset:
  - state = FETCH, retired = 0.
  - All strobes are forced to 0 while rst is high.
  - The first ir_write occurs in the first cycle after rst deasserts.
- Latency in cycles, FETCH to FETCH:
  - NOP, J, illegal: 2.
  - LI, LUI, branch: 3.
  - R-type and I-type ALU: 4.
  - Store: 4 + wait.
  - Load: 5 + wait, where wait = cycles with dmem_ready low in MEM.
- dmem_ready may be high on the first MEM cycle (zero-wait). It is ignored outside MEM.
- `retired` increments on the last cycle of each instruction and wraps modulo 2^CNT_W.
- rst asserted mid-instruction:
  - Immediate return to FETCH.
  - No strobe glitch; pending reg_write or mem_write is dropped.

## Structure
- Package `mc_ctrl_pkg` holds:
  - opcode localparams,
  - state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4),
  - alu_op, pc_src, alu_src_b and wb_sel codes.
- One sub-module, `mc_opdecode`: combinational opcode to class/alu_op/select decoder. The FSM and counter stay in the top module.

## Test plan
- Reset then NOP, ADDI r1, ADDI r2, ADDI r3 0xFFF8 → states 0,1,0,1,2,4,... with reg_write once per ADDI; retired=4 after 14 cycles.
- BEQ with zero=1, then BEQ with zero=0 → pc_write/pc_src=1 only in the first EXEC; both retire in 3 cycles.
- BLE with lt=0,zero=1 and BLT with lt=0,zero=1 → taken and not taken, respectively.
- LWI with dmem_ready low for 3 cycles → mem_read held for 4 cycles, then WB with wb_sel=1; total 8 cycles.
- J (opcode 000001, IR[25:0]=0) → pc_write with pc_src=2 in DECODE; next ir_write 1 cycle later.
- Opcode 101010 → illegal pulses 1 cycle, no reg_write/mem_write; rst asserted during SW in MEM → mem_write low that same cycle, state=FETCH.
